// File: rtl/seg_text_buffer.sv
// seg_text_buffer: character entry buffer that feeds the 8-digit multiplexed
// 7-segment scanner. Incoming character codes are turned into segment
// patterns. The patterns are kept left-aligned in an 8-digit text store, and
// the registered seg_val image adds a blinking cursor after the newest char.
//
// Handshake: a command is taken on a rising edge where in_valid and in_ready
// are both 1. in_ready only drops while freeze holds an occupied stage 1. A
// producer must keep in_valid, in_cmd and in_char stable until the command
// is taken.
module seg_text_buffer #(
   parameter int unsigned BLINK_DIV  = 25_000_000,
   parameter logic [7:0]  CURSOR_PAT = 8'h08
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_cmd,
   input  logic [5:0]  in_char,
   input  logic        freeze,
   output logic [63:0] seg_val,
   output logic [3:0]  char_cnt,
   output logic        overflow
);

   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   localparam logic [1:0] CMD_PUSH  = 2'b00;
   localparam logic [1:0] CMD_BKSP  = 2'b01;
   localparam logic [1:0] CMD_CLEAR = 2'b10;
   localparam logic [1:0] CMD_DP    = 2'b11;

   // Character code to segment pattern (bit0=a .. bit6=g, dp always 0).
   function automatic logic [7:0] font(input logic [5:0] code);
      logic [7:0] pat;
      case (code)
         6'd0:    pat = 8'h3F;
         6'd1:    pat = 8'h06;
         6'd2:    pat = 8'h5B;
         6'd3:    pat = 8'h4F;
         6'd4:    pat = 8'h66;
         6'd5:    pat = 8'h6D;
         6'd6:    pat = 8'h7D;
         6'd7:    pat = 8'h07;
         6'd8:    pat = 8'h7F;
         6'd9:    pat = 8'h6F;
         6'd10:   pat = 8'h77; // A
         6'd11:   pat = 8'h7C; // B
         6'd12:   pat = 8'h39; // C
         6'd13:   pat = 8'h5E; // D
         6'd14:   pat = 8'h79; // E
         6'd15:   pat = 8'h71; // F
         6'd16:   pat = 8'h3D; // G
         6'd17:   pat = 8'h76; // H
         6'd18:   pat = 8'h30; // I
         6'd19:   pat = 8'h1E; // J
         6'd20:   pat = 8'h75; // K
         6'd21:   pat = 8'h38; // L
         6'd22:   pat = 8'h37; // M
         6'd23:   pat = 8'h54; // N
         6'd24:   pat = 8'h5C; // O
         6'd25:   pat = 8'h73; // P
         6'd26:   pat = 8'h67; // Q
         6'd27:   pat = 8'h50; // R
         6'd28:   pat = 8'h6D; // S
         6'd29:   pat = 8'h78; // T
         6'd30:   pat = 8'h3E; // U
         6'd31:   pat = 8'h1C; // V
         6'd32:   pat = 8'h2A; // W
         6'd33:   pat = 8'h49; // X
         6'd34:   pat = 8'h6E; // Y
         6'd35:   pat = 8'h5B; // Z
         6'd37:   pat = 8'h40; // dash
         default: pat = 8'h00; // blank (36 and 38..63)
      endcase
      return pat;
   endfunction

   // Stage 1: one captured command with its encoded pattern.
   logic       s1_full;
   logic [1:0] s1_cmd;
   logic [7:0] s1_pat;
   logic       accept;
   logic       apply;

   // Text store, and the state that is computed for the next edge.
   logic [63:0]   text;
   logic [63:0]   text_next;
   logic [63:0]   seg_next;
   logic [3:0]    cnt;
   logic [3:0]    cnt_next;
   logic          ovf_next;
   logic          full;
   logic [2:0]    wr_idx;
   logic [2:0]    nw_idx;
   logic [2:0]    cur_idx;
   logic [BW-1:0] blink_cnt;
   logic [BW-1:0] blink_cnt_next;
   logic          blink_on;
   logic          blink_on_next;

   assign in_ready = ~(freeze & s1_full);
   assign accept   = in_valid & in_ready;
   assign apply    = s1_full & ~freeze;
   assign char_cnt = cnt;

   assign full    = (cnt == 4'd8);
   // The free slot for the next push is digit 7-cnt. It is only used when cnt < 8.
   assign wr_idx  = 3'd7 - cnt[2:0];
   // The newest char sits at digit 8-cnt. The modulo-8 subtraction maps cnt=8 to digit 0.
   assign nw_idx  = 3'd0 - cnt[2:0];
   assign cur_idx = 3'd7 - cnt_next[2:0];

   // Capture a command on handshake. When freeze is 0, stage 1 drains into stage 2 every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_full <= 1'b0;
         s1_cmd  <= CMD_PUSH;
         s1_pat  <= 8'h00;
      end else if (accept) begin
         s1_full <= 1'b1;
         s1_cmd  <= in_cmd;
         s1_pat  <= font(in_char);
      end else if (!freeze) begin
         s1_full <= 1'b0;
      end
   end

   // Stage 2: work out the buffer contents after the staged command is applied.
   always_comb begin
      text_next = text;
      cnt_next  = cnt;
      ovf_next  = 1'b0;
      if (apply) begin
         case (s1_cmd)
            CMD_PUSH: begin
               if (full) begin
                  // Scroll: the oldest digit (7) falls off and the new char lands at digit 0.
                  text_next = {text[55:0], s1_pat};
                  ovf_next  = 1'b1;
               end else begin
                  text_next[{wr_idx, 3'b000} +: 8] = s1_pat;
                  cnt_next = cnt + 4'd1;
               end
            end
            CMD_BKSP: begin
               if (cnt != 4'd0) begin
                  text_next[{nw_idx, 3'b000} +: 8] = 8'h00;
                  cnt_next = cnt - 4'd1;
               end
            end
            CMD_CLEAR: begin
               text_next = 64'h0;
               cnt_next  = 4'd0;
            end
            default: begin
               if (cnt != 4'd0) begin
                  text_next[{nw_idx, 3'b111}] = ~text[{nw_idx, 3'b111}];
               end
            end
         endcase
      end
   end

   // Blink timebase: the phase flips on the last count of each half-period.
   always_comb begin
      blink_cnt_next = blink_cnt + 1'b1;
      blink_on_next  = blink_on;
      if (blink_cnt == BLINK_LAST) begin
         blink_cnt_next = '0;
         blink_on_next  = ~blink_on;
      end
   end

   // Cursor overlay on the next-state image, so seg_val tracks the buffer without extra delay.
   always_comb begin
      seg_next = text_next;
      if (!cnt_next[3] && blink_on_next) begin
         seg_next[{cur_idx, 3'b000} +: 8] = text_next[{cur_idx, 3'b000} +: 8] | CURSOR_PAT;
      end
   end

   // Buffer, display image and blink state all advance together. Freeze holds every one of them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         text      <= 64'h0;
         cnt       <= 4'd0;
         seg_val   <= 64'h0;
         overflow  <= 1'b0;
         blink_cnt <= '0;
         blink_on  <= 1'b0;
      end else if (freeze) begin
         overflow <= 1'b0;
      end else begin
         text      <= text_next;
         cnt       <= cnt_next;
         seg_val   <= seg_next;
         overflow  <= ovf_next;
         blink_cnt <= blink_cnt_next;
         blink_on  <= blink_on_next;
      end
   end

endmodule

// File: tb/tb_seg_text_buffer.sv
// tb_seg_text_buffer: directed commands with hand-computed buffer images.
// The driver queues the image expected after each accepted command. The
// monitor retires queue entries as commands land and checks the outputs
// every cycle, with the blinking cursor added on top.
module tb_seg_text_buffer;

   localparam int BD = 4;
   localparam logic [1:0] P = 2'b00;
   localparam logic [1:0] B = 2'b01;
   localparam logic [1:0] C = 2'b10;
   localparam logic [1:0] D = 2'b11;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_cmd;
   logic [5:0]  in_char;
   logic        freeze;
   logic [63:0] seg_val;
   logic [3:0]  char_cnt;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   // Scoreboard entries are {overflow, char_cnt, image}.
   logic [68:0] exp_q[$];

   logic [63:0] cur_img    = 64'h0;
   logic [3:0]  cur_cnt    = 4'd0;
   logic        exp_ovf    = 1'b0;
   logic        m_s1       = 1'b0;
   logic        underflow  = 1'b0;
   logic        smp_acc    = 1'b0;
   logic        smp_freeze = 1'b0;
   int          bc         = 0;
   logic        ph         = 1'b0;

   logic [63:0] t2_img [10];

   seg_text_buffer #(.BLINK_DIV(BD), .CURSOR_PAT(8'h08)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_cmd(in_cmd), .in_char(in_char), .freeze(freeze),
      .seg_val(seg_val), .char_cnt(char_cnt), .overflow(overflow)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Reference timing: a command lands on the first unfrozen edge after it is
   // accepted. The blink phase flips every BD unfrozen cycles.
   always @(posedge clk or negedge rst) begin
      logic [68:0] item;
      if (!rst) begin
         m_s1    = 1'b0;
         cur_img = 64'h0;
         cur_cnt = 4'd0;
         exp_ovf = 1'b0;
         bc      = 0;
         ph      = 1'b0;
         exp_q.delete();
      end else begin
         exp_ovf   = 1'b0;
         underflow = 1'b0;
         if (m_s1 && !smp_freeze) begin
            if (exp_q.size() == 0) begin
               underflow = 1'b1;
            end else begin
               item    = exp_q.pop_front();
               cur_img = item[63:0];
               cur_cnt = item[67:64];
               exp_ovf = item[68];
            end
         end
         if (smp_acc) m_s1 = 1'b1;
         else if (!smp_freeze) m_s1 = 1'b0;
         if (!smp_freeze) begin
            if (bc == BD - 1) begin
               bc = 0;
               ph = ~ph;
            end else begin
               bc = bc + 1;
            end
         end
      end
   end

   // Monitor: compare the outputs on every falling edge, then sample the handshake.
   always @(negedge clk) begin
      logic [63:0] want;
      int idx;
      want = cur_img;
      if (cur_cnt < 4'd8 && ph) begin
         idx = 7 - int'(cur_cnt);
         want[idx*8 +: 8] = cur_img[idx*8 +: 8] | 8'h08;
      end
      chk("seg_val", seg_val, want);
      chk("char_cnt", 64'(char_cnt), 64'(cur_cnt));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("sb_underflow", 64'(underflow), 64'd0);
      smp_acc    = in_valid & in_ready & rst;
      smp_freeze = freeze;
   end

   // Driver: present a command until it is taken, then queue its expected result.
   task automatic issue(input logic [1:0] cmd, input logic [5:0] ch,
                        input logic [63:0] img, input logic [3:0] cnt, input logic ovf);
      logic rdy;
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_cmd   = cmd;
      in_char  = ch;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy && rst) begin
            exp_q.push_back({ovf, cnt, img});
            done = 1'b1;
         end
      end
      #1 in_valid = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL accept_timeout: cmd %0d char %0d got no accept want accept within 50 cycles", cmd, ch);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Stimulus
   initial begin
      t2_img[0] = 64'h3F00000000000000;
      t2_img[1] = 64'h3F06000000000000;
      t2_img[2] = 64'h3F065B0000000000;
      t2_img[3] = 64'h3F065B4F00000000;
      t2_img[4] = 64'h3F065B4F66000000;
      t2_img[5] = 64'h3F065B4F666D0000;
      t2_img[6] = 64'h3F065B4F666D7D00;
      t2_img[7] = 64'h3F065B4F666D7D07;
      t2_img[8] = 64'h065B4F666D7D077F;
      t2_img[9] = 64'h5B4F666D7D077F6F;

      rst = 1'b0; in_valid = 1'b0; in_cmd = 2'b00; in_char = 6'd0; freeze = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk("rst_seg_val", seg_val, 64'h0);
      chk("rst_char_cnt", 64'(char_cnt), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // HELLO, back to back
      issue(P, 6'd17, 64'h7600000000000000, 4'd1, 1'b0);
      issue(P, 6'd14, 64'h7679000000000000, 4'd2, 1'b0);
      issue(P, 6'd21, 64'h7679380000000000, 4'd3, 1'b0);
      issue(P, 6'd21, 64'h7679383800000000, 4'd4, 1'b0);
      issue(P, 6'd24, 64'h767938385C000000, 4'd5, 1'b0);
      idle(4);

      // Backspace, decimal point, clear, and no-ops on an empty buffer
      issue(B, 6'd0, 64'h7679383800000000, 4'd4, 1'b0);
      issue(B, 6'd0, 64'h7679380000000000, 4'd3, 1'b0);
      issue(D, 6'd0, 64'h7679B80000000000, 4'd3, 1'b0);
      issue(D, 6'd0, 64'h7679380000000000, 4'd3, 1'b0);
      issue(D, 6'd0, 64'h7679B80000000000, 4'd3, 1'b0);
      issue(C, 6'd0, 64'h0, 4'd0, 1'b0);
      issue(B, 6'd0, 64'h0, 4'd0, 1'b0);
      issue(D, 6'd0, 64'h0, 4'd0, 1'b0);
      idle(3);

      // Font corners: Z, dash, high blank, M, W
      issue(P, 6'd35, 64'h5B00000000000000, 4'd1, 1'b0);
      issue(P, 6'd37, 64'h5B40000000000000, 4'd2, 1'b0);
      issue(P, 6'd45, 64'h5B40000000000000, 4'd3, 1'b0);
      issue(P, 6'd22, 64'h5B40003700000000, 4'd4, 1'b0);
      issue(P, 6'd32, 64'h5B4000372A000000, 4'd5, 1'b0);
      issue(C, 6'd0, 64'h0, 4'd0, 1'b0);
      idle(2);

      // Ten digits: fill, then scroll twice
      for (int i = 0; i < 10; i++) begin
         issue(P, 6'(i), t2_img[i], (i < 8) ? 4'(i + 1) : 4'd8, (i >= 8));
      end
      idle(3);
      issue(B, 6'd0, 64'h5B4F666D7D077F00, 4'd7, 1'b0);
      issue(C, 6'd0, 64'h0, 4'd0, 1'b0);
      idle(3);

      // Blink on an empty buffer, paused by freeze
      idle(12);
      freeze = 1'b1;
      idle(10);
      freeze = 1'b0;
      idle(12);

      // Freeze with stage 1 full: the second command stalls until release
      freeze = 1'b1;
      issue(P, 6'd10, 64'h7700000000000000, 4'd1, 1'b0);
      fork
         issue(P, 6'd11, 64'h777C000000000000, 4'd2, 1'b0);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("frozen_in_ready", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1 freeze = 1'b0;
         end
      join
      idle(4);

      // Async reset right after an accept discards the staged push
      issue(P, 6'd12, 64'h777C390000000000, 4'd3, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_seg_val", seg_val, 64'h0);
      chk("async_rst_char_cnt", 64'(char_cnt), 64'd0);
      chk("async_rst_overflow", 64'(overflow), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      idle(10);
      chk("post_rst_char_cnt", 64'(char_cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
